// File: rtl/lsu_load_unit_pkg.sv
// Shared load-path definitions: operand widths, LSU opcodes, load FSM states, request record.
package lsu_load_unit_pkg;

    localparam int DEF_CPU_WIDTH     = 32;
    localparam int DEF_LSU_OPT_WIDTH = 4;

    // Store codes come first; load codes sit beside them in the same opcode space.
    localparam logic [DEF_LSU_OPT_WIDTH-1:0] LSU_SB  = 4'h1;
    localparam logic [DEF_LSU_OPT_WIDTH-1:0] LSU_SH  = 4'h2;
    localparam logic [DEF_LSU_OPT_WIDTH-1:0] LSU_SW  = 4'h3;
    localparam logic [DEF_LSU_OPT_WIDTH-1:0] LSU_LB  = 4'h4;
    localparam logic [DEF_LSU_OPT_WIDTH-1:0] LSU_LH  = 4'h5;
    localparam logic [DEF_LSU_OPT_WIDTH-1:0] LSU_LW  = 4'h6;
    localparam logic [DEF_LSU_OPT_WIDTH-1:0] LSU_LBU = 4'h7;
    localparam logic [DEF_LSU_OPT_WIDTH-1:0] LSU_LHU = 4'h8;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_ISSUE = 2'd1,
        LD_WAIT  = 2'd2,
        LD_RESP  = 2'd3
    } ld_state_t;

    typedef struct packed {
        logic [DEF_LSU_OPT_WIDTH-1:0] opt;
        logic [1:0]                   off;
    } ld_req_t;

    // A load is legal when the opcode is a load and the access is naturally aligned.
    function automatic logic ld_legal(input logic [DEF_LSU_OPT_WIDTH-1:0] opt,
                                      input logic [1:0] off);
        case (opt)
            LSU_LB, LSU_LBU: return 1'b1;
            LSU_LH, LSU_LHU: return ~off[0];
            LSU_LW:          return (off == 2'b00);
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_unit_load_extend.sv
// Selects the addressed byte/halfword/word of a read word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module lsu_load_unit_load_extend
    import lsu_load_unit_pkg::*;
#(
    parameter int W = DEF_CPU_WIDTH
) (
    input  logic [DEF_LSU_OPT_WIDTH-1:0] opt,
    input  logic [1:0]                   off,
    input  logic [W-1:0]                 word,
    output logic [W-1:0]                 data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = word[{off[1], 4'b0000} +: 16];
        data   = '0;
        case (opt)
            LSU_LB:  data = {{(W-8){byte_v[7]}}, byte_v};
            LSU_LBU: data = {{(W-8){1'b0}}, byte_v};
            LSU_LH:  data = {{(W-16){half_v[15]}}, half_v};
            LSU_LHU: data = {{(W-16){1'b0}}, half_v};
            LSU_LW:  data = word;
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_load_unit.sv
// Load unit: takes one EXU load, issues one aligned memory read, returns extended data with a done pulse.
// Latency: accept -> ld_done 2 cycles minimum, +1 per cycle memory stalls, bounded by TIMEOUT_CYCLES.
// Backpressure: ld_ready is high only in IDLE; one load in flight, at least one idle cycle between loads.
module lsu_load_unit
    import lsu_load_unit_pkg::*;
#(
    parameter int CPU_WIDTH      = DEF_CPU_WIDTH,
    parameter int LSU_OPT_WIDTH  = DEF_LSU_OPT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [LSU_OPT_WIDTH-1:0] lsu_opt_code,
    input  logic [CPU_WIDTH-1:0]     addr,
    output logic                     ld_done,
    output logic [CPU_WIDTH-1:0]     data_load,
    output logic                     ld_err,
    output logic                     mem_rd_en,
    output logic [CPU_WIDTH-1:0]     mem_rd_addr,
    input  logic                     mem_rd_valid,
    input  logic [CPU_WIDTH-1:0]     mem_rd_data
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ld_state_t              state;
    ld_req_t                req;
    logic [CNT_W-1:0]       wait_cnt;
    logic [CPU_WIDTH-1:0]   ext_data;

    assign ld_ready = (state == LD_IDLE);

    // Extraction always uses the request latched at accept, never the live EXU inputs.
    lsu_load_unit_load_extend #(
        .W (CPU_WIDTH)
    ) u_extend (
        .opt  (req.opt),
        .off  (req.off),
        .word (mem_rd_data),
        .data (ext_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= LD_IDLE;
            req         <= '0;
            wait_cnt    <= '0;
            ld_done     <= 1'b0;
            ld_err      <= 1'b0;
            data_load   <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
        end else begin
            ld_done   <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (ld_valid) begin
                        req <= '{opt: lsu_opt_code, off: addr[1:0]};
                        if (ld_legal(lsu_opt_code, addr[1:0])) begin
                            state       <= LD_ISSUE;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= {addr[CPU_WIDTH-1:2], 2'b00};
                        end else begin
                            state     <= LD_RESP;
                            ld_done   <= 1'b1;
                            ld_err    <= 1'b1;
                            data_load <= '0;
                        end
                    end
                end
                LD_ISSUE: begin
                    if (mem_rd_valid) begin
                        state     <= LD_RESP;
                        ld_done   <= 1'b1;
                        ld_err    <= 1'b0;
                        data_load <= ext_data;
                    end else begin
                        state <= LD_WAIT;
                    end
                end
                LD_WAIT: begin
                    // Data arriving on the final wait cycle still beats the timeout.
                    if (mem_rd_valid) begin
                        state     <= LD_RESP;
                        wait_cnt  <= '0;
                        ld_done   <= 1'b1;
                        ld_err    <= 1'b0;
                        data_load <= ext_data;
                    end else if (wait_cnt == CNT_LAST) begin
                        state     <= LD_RESP;
                        wait_cnt  <= '0;
                        ld_done   <= 1'b1;
                        ld_err    <= 1'b1;
                        data_load <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                LD_RESP: begin
                    state <= LD_IDLE;
                end
                default: begin
                    state <= LD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_load_unit.sv
// Scoreboard bench for lsu_load_unit: driver pushes model results, negedge monitor pops on ld_done.
module tb_lsu_load_unit;
    import lsu_load_unit_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  lsu_opt_code;
    logic [31:0] addr;
    logic        ld_done;
    logic [31:0] data_load;
    logic        ld_err;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;

    always #5 clk = ~clk;

    lsu_load_unit #(
        .CPU_WIDTH      (32),
        .LSU_OPT_WIDTH  (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .lsu_opt_code (lsu_opt_code),
        .addr         (addr),
        .ld_done      (ld_done),
        .data_load    (data_load),
        .ld_err       (ld_err),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          rd;
        logic [31:0] raddr;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          rd_cnt = 0;
    bit          busy = 0;
    logic [31:0] last_data = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: d = cycles after the read strobe that memory answers (0 = same cycle).
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] w, input int d);
        exp_t        e;
        int          off;
        logic [31:0] b, h;
        bit          legal;
        off   = int'(a % 4);
        legal = (op == LSU_LB || op == LSU_LBU) ||
                ((op == LSU_LH || op == LSU_LHU) && (off % 2 == 0)) ||
                (op == LSU_LW && off == 0);
        e.raddr = a - 32'(off);
        if (!legal) begin
            e.data = 0; e.err = 1; e.lat = 1; e.rd = 0;
        end else if (d > TO) begin
            e.data = 0; e.err = 1; e.lat = 2 + TO; e.rd = 1;
        end else begin
            b = (w >> (8 * off)) & 32'hFF;
            h = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (op == LSU_LB)       e.data = (b > 127) ? b - 32'd256 : b;
            else if (op == LSU_LBU) e.data = b;
            else if (op == LSU_LH)  e.data = (h > 32767) ? h - 32'd65536 : h;
            else if (op == LSU_LHU) e.data = h;
            else                    e.data = w;
            e.err = 0; e.lat = 2 + d; e.rd = 1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rstn) begin
            sbq.delete();
            busy      = 0;
            rd_cnt    = 0;
            last_data = '0;
        end else begin
            check("ld_ready", 32'(ld_ready), 32'(!busy));
            if (mem_rd_en) begin
                rd_cnt++;
                if (sbq.size() > 0) check("mem_rd_addr", mem_rd_addr, sbq[0].raddr);
            end
            if (ld_done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_ld_done", 32'(ld_done), 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    check("data_load", data_load, mon_e.data);
                    check("ld_err", 32'(ld_err), 32'(mon_e.err));
                    check("latency", 32'(cyc - acc_cyc), 32'(mon_e.lat));
                    check("rd_strobes", 32'(rd_cnt), 32'(mon_e.rd));
                    last_data = mon_e.data;
                end
                rd_cnt = 0;
                busy   = 0;
            end else begin
                check("data_hold", data_load, last_data);
            end
            if (ld_valid && ld_ready) begin
                acc_cyc = cyc;
                busy    = 1;
            end
        end
    end

    task automatic do_load(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] w, input int d);
        exp_t e;
        bit   seen;
        e = model(op, a, w, d);
        sbq.push_back(e);
        @(posedge clk); #1;
        ld_valid = 1; lsu_opt_code = op; addr = a;
        @(posedge clk); #1;
        ld_valid = 0; lsu_opt_code = 4'($urandom); addr = $urandom;
        if (e.rd == 1) begin
            seen = 0;
            for (int i = 0; i < 4 && !seen; i++) begin
                @(negedge clk);
                seen = mem_rd_en;
            end
            if (seen) begin
                repeat (d) @(negedge clk);
                mem_rd_data  = w;
                mem_rd_valid = 1;
                @(negedge clk);
                mem_rd_valid = 0;
                mem_rd_data  = $urandom;
            end
        end
        for (int i = 0; i < TO + 20 && sbq.size() != 0; i++) @(negedge clk);
        if (sbq.size() != 0) begin
            check("done_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        if ($urandom_range(0, 3) == 0) begin
            mem_rd_data  = $urandom;
            mem_rd_valid = 1;
            @(negedge clk);
            mem_rd_valid = 0;
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic reset_mid_wait();
        @(posedge clk); #1;
        ld_valid = 1; lsu_opt_code = LSU_LW; addr = 32'h8000_0010;
        @(posedge clk); #1;
        ld_valid = 0;
        repeat (4) @(negedge clk);
        rstn = 0;
        #1;
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        check("rst_ld_done", 32'(ld_done), 32'd0);
        check("rst_data_load", data_load, 32'd0);
        check("rst_ld_err", 32'(ld_err), 32'd0);
        check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_mem_rd_addr", mem_rd_addr, 32'd0);
        @(negedge clk);
        rstn = 1;
        mem_rd_data  = 32'h1234_5678;
        mem_rd_valid = 1;
        @(negedge clk);
        mem_rd_valid = 0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [3:0] ops[5];
        logic [3:0] op;
        int         d;
        ops = '{LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
        rstn = 0; ld_valid = 0; lsu_opt_code = '0; addr = '0;
        mem_rd_valid = 0; mem_rd_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ld_ready", 32'(ld_ready), 32'd1);
        check("reset_ld_done", 32'(ld_done), 32'd0);
        check("reset_data_load", data_load, 32'd0);
        check("reset_mem_rd_en", 32'(mem_rd_en), 32'd0);
        check("reset_mem_rd_addr", mem_rd_addr, 32'd0);
        @(posedge clk); #1;
        rstn = 1;

        do_load(LSU_LW,  32'h8000_0004, 32'hDEAD_BEEF, 0);
        do_load(LSU_LB,  32'h8000_0001, 32'h8899_AABB, 0);
        do_load(LSU_LBU, 32'h8000_0001, 32'h8899_AABB, 1);
        do_load(LSU_LH,  32'h8000_0002, 32'h8899_AABB, 0);
        do_load(LSU_LHU, 32'h8000_0002, 32'h8899_AABB, 2);
        do_load(LSU_LH,  32'h8000_0001, 32'h8899_AABB, 0);
        do_load(LSU_LW,  32'h8000_0002, 32'h8899_AABB, 0);
        do_load(LSU_SW,  32'h8000_0000, 32'h8899_AABB, 0);
        do_load(LSU_LW,  32'h8000_0008, 32'hCAFE_F00D, 5);
        do_load(LSU_LW,  32'h8000_000C, 32'h0BAD_CAFE, TO);
        do_load(LSU_LW,  32'h8000_0010, 32'h1111_2222, TO + 1);
        do_load(LSU_LW,  32'h8000_0014, 32'h3333_4444, TO + 3);
        do_load(LSU_LW,  32'h8000_0018, 32'h5555_6666, 1);
        reset_mid_wait();
        do_load(LSU_LHU, 32'h8000_0022, 32'hF00D_8001, 0);

        for (int i = 0; i < 200; i++) begin
            op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 4)];
            d  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, TO + 3) : $urandom_range(0, 4);
            do_load(op, $urandom, $urandom, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
